mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares one single-port unified memory between the instruction fetch stage and the load/store (MEM) stage of the pipelined core. It grants one requester at a time and drives a variable-latency req/ack memory port. It returns read data to the granted requester, generates `stall_if_o`/`stall_mem_o` for the hazard logic, and prevents instruction-fetch starvation with a bounded data-priority counter. It sits between the two pipeline stages and the memory model/SoC bus.

## Interface

Parameters:
- `MAX_DATA_BURST`, default 4: maximum consecutive data grants while a fetch is pending; range 1–7.

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `if_req_i`  in  1  fetch request; level, held until `if_valid_o`
- `if_addr_i`  in  32  fetch address; stable while `if_req_i` is high
- `flush_if_i`  in  1  discard the in-flight/returning fetch result
- `if_data_o`  out  32  fetched instruction
- `if_valid_o`  out  1  one-cycle pulse, `if_data_o` valid
- `stall_if_o`  out  1  `if_req_i & ~if_valid_o`
- `ls_req_i`  in  1  load/store request; level, held until `ls_valid_o`
- `ls_we_i`  in  1  1 = store
- `ls_addr_i`  in  32  data address
- `ls_wdata_i`  in  32  store data
- `ls_be_i`  in  4  byte enables
- `ls_rdata_o`  out  32  load data; 0 for stores
- `ls_valid_o`  out  1  one-cycle pulse, access complete
- `stall_mem_o`  out  1  `ls_req_i & ~ls_valid_o`
- `mem_req_o`  out  1  memory request, held until ack
- `mem_we_o`  out  1  write enable
- `mem_addr_o`  out  32  address
- `mem_wdata_o`  out  32  write data
- `mem_be_o`  out  4  byte enables; 4'hF for fetches
- `mem_rdata_i`  in  32  read data, valid in the ack cycle
- `mem_ack_i`  in  1  completion, one cycle, may arrive in the first cycle of `mem_req_o`

## Operation

States are IDLE, BUSY_I and BUSY_D.

- **IDLE:**
  - If `ls_req_i && (!if_req_i || dcount < MAX_DATA_BURST)`, the data requester wins and the next state is BUSY_D.
  - Otherwise, if `if_req_i`, the fetch wins and the next state is BUSY_I.
  - Otherwise the block stays in IDLE.
  - On a grant, request fields are latched into `mem_*_o` registers. Fetch grants latch `we=0` and `be=4'hF`.
- **BUSY_x:**
  - `mem_req_o`=1 and all `mem_*_o` fields are held stable.
  - When `mem_ack_i`=1, `mem_rdata_i` is captured and the next state is IDLE.
  - The matching valid pulse is raised in the following cycle.
- **dcount (3-bit):**
  - On a D grant with `if_req_i`=1: increment, saturating at `MAX_DATA_BURST`.
  - On a D grant with `if_req_i`=0: clear to 0.
  - On any I grant: clear to 0.
- **Request re-sampling:** a requester's `req_i` sampled in its own valid cycle counts as a new request. The requester must present the next address, or deassert, in that cycle.
- **Flush:** `drop` flag.
  - Set if `flush_if_i`=1 in any cycle of BUSY_I, including the ack cycle.
  - When set, the fetch completes on the memory side, `if_valid_o` is suppressed and `if_data_o` is unchanged.
  - Cleared on the next I grant.
  - `flush_if_i` has no effect in IDLE or BUSY_D.
- **Stores:** `ls_rdata_o` is written as 0 on completion.

## Timing

- **Reset (async):**
  - State is IDLE.
  - `mem_req_o`, `mem_we_o`, `if_valid_o`, `ls_valid_o` = 0.
  - `mem_addr_o`, `mem_wdata_o`, `if_data_o`, `ls_rdata_o` = 0.
  - `mem_be_o`, `dcount` = 0; `drop` = 0.
  - An ack arriving during or just after reset is ignored.
- **Latency:**
  - Request sampled at edge N.
  - `mem_req_o` high from cycle N+1.
  - Ack in cycle N+k (k≥1).
  - Valid pulse in cycle N+k+1.
- **Minimum latency:** 2 cycles from request to valid. Back-to-back throughput is one access per 2 cycles, because the arbiter is in IDLE during each valid cycle.
- **Simultaneous requests:** data wins unless `dcount == MAX_DATA_BURST`, in which case the fetch wins.
- **Request drops:** a request dropped before it is granted is never issued. Dropping `req_i` while BUSY is illegal; the transaction still completes and its valid pulse is still produced.
- **Stall outputs:** purely combinational from inputs and registered valids; no register.

## Test plan

- **Single fetch:** reset release, then `if_req_i`=1 with `if_addr_i`=0x100; memory acks in the first cycle with 0x00500093.
  - `mem_req_o` high 1 cycle with addr 0x100 and be F.
  - `if_valid_o` pulses 2 cycles after the request with `if_data_o`=0x00500093.
  - `stall_if_o` is high for exactly the 2 preceding cycles.
- **Store with wait states:** `ls_req_i`, `ls_we_i`=1, addr 0x2000, wdata 0xDEADBEEF, be 4'b0011; ack after 3 cycles.
  - Memory fields are stable for all 3 cycles.
  - `ls_valid_o` pulses once with `ls_rdata_o`=0.
- **Priority and fairness:** `if_req_i` and `ls_req_i` held high continuously, `MAX_DATA_BURST`=4, ack 1 cycle.
  - Grant order is D,D,D,D,I,D,D,D,D,I…
  - `if_valid_o` appears every 10th cycle.
- **Flush during fetch:** fetch of 0x200 with ack delayed 4 cycles; `flush_if_i` pulsed in the 2nd BUSY_I cycle.
  - `if_valid_o` never pulses and `if_data_o` is unchanged.
  - The next fetch, of 0x300, returns normally.
- **Async reset mid-access:** `reset_n` dropped in cycle 2 of BUSY_D, asynchronously with respect to `clk`.
  - All outputs are 0 immediately.
  - A late `mem_ack_i` produces no valid pulse.
  - After release, a new fetch completes with 2-cycle latency.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port req/ack memory between instruction fetch and load/store.
// Data wins ties, but a bounded burst counter keeps a waiting fetch from starving.
module mem_port_arbiter #(
  parameter int MAX_DATA_BURST = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  input  logic        flush_if_i,
  output logic [31:0] if_data_o,
  output logic        if_valid_o,
  output logic        stall_if_o,
  input  logic        ls_req_i,
  input  logic        ls_we_i,
  input  logic [31:0] ls_addr_i,
  input  logic [31:0] ls_wdata_i,
  input  logic [3:0]  ls_be_i,
  output logic [31:0] ls_rdata_o,
  output logic        ls_valid_o,
  output logic        stall_mem_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;
  localparam logic [2:0] BURST_MAX = 3'(MAX_DATA_BURST);

  logic [1:0] state;
  logic [2:0] dcount;
  logic       drop;
  logic       grant_d, grant_i;

  assign grant_d = (state == IDLE) && ls_req_i && (!if_req_i || (dcount < BURST_MAX));
  assign grant_i = (state == IDLE) && !grant_d && if_req_i;

  assign stall_if_o  = if_req_i & ~if_valid_o;
  assign stall_mem_o = ls_req_i & ~ls_valid_o;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      dcount      <= 3'd0;
      drop        <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= 32'd0;
      mem_wdata_o <= 32'd0;
      mem_be_o    <= 4'd0;
      if_data_o   <= 32'd0;
      if_valid_o  <= 1'b0;
      ls_rdata_o  <= 32'd0;
      ls_valid_o  <= 1'b0;
    end else begin
      if_valid_o <= 1'b0;
      ls_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            state       <= BUSY_D;
            mem_req_o   <= 1'b1;
            mem_we_o    <= ls_we_i;
            mem_addr_o  <= ls_addr_i;
            mem_wdata_o <= ls_wdata_i;
            mem_be_o    <= ls_be_i;
            // Only consecutive data grants against a waiting fetch count toward the burst.
            if (!if_req_i)               dcount <= 3'd0;
            else if (dcount < BURST_MAX) dcount <= dcount + 3'd1;
          end else if (grant_i) begin
            state       <= BUSY_I;
            mem_req_o   <= 1'b1;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= if_addr_i;
            mem_wdata_o <= 32'd0;
            mem_be_o    <= 4'hF;
            dcount      <= 3'd0;
            drop        <= 1'b0;
          end
        end
        BUSY_I: begin
          if (flush_if_i) drop <= 1'b1;
          if (mem_ack_i) begin
            state     <= IDLE;
            mem_req_o <= 1'b0;
            // A flush in the ack cycle itself must also kill the result.
            if (!(drop || flush_if_i)) begin
              if_valid_o <= 1'b1;
              if_data_o  <= mem_rdata_i;
            end
          end
        end
        BUSY_D: begin
          if (mem_ack_i) begin
            state      <= IDLE;
            mem_req_o  <= 1'b0;
            ls_valid_o <= 1'b1;
            ls_rdata_o <= mem_we_o ? 32'd0 : mem_rdata_i;
          end
        end
        default: begin
          state     <= IDLE;
          mem_req_o <= 1'b0;
        end
      endcase
    end
  end
endmodule
